fuzz_stim_sequencer: RTL and testbench

//  Run controller and stimulus source for the fuzz harness DUT wrapper (top: in_flat/out_flat).

---
 rtl/fuzz_stim_sequencer.sv | 146 ++++++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_stim_sequencer.sv
// Fuzz run controller: resets the DUT, then streams LCG-filled vectors.
// Ports: clk/rst, start/abort/seed/cycles control, vec_* handshake,
// dut_rst_n to the DUT, cyc_count/busy/done status.
module fuzz_stim_sequencer #(
  parameter int IN_W         = 263,
  parameter int RESET_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     seed,
  input  logic [31:0]     cycles,
  output logic            vec_valid,
  input  logic            vec_ready,
  output logic [IN_W-1:0] vec_data,
  output logic            dut_rst_n,
  output logic [31:0]     cyc_count,
  output logic            busy,
  output logic            done
);

  localparam int NWORDS = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NWORDS - 1);
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int RC_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [31:0] MULT = 32'h41C64E6D;
  localparam logic [31:0] INC  = 32'h3039;

  typedef enum logic [2:0] {
    IDLE,
    RSTDUT,
    FILL,
    PRESENT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       lcg_q, lcg_d;
  logic [31:0]       budget_q, budget_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [IN_W-1:0]   wr_data;
  logic [31:0]       lcg_step;

  // Product is truncated to 32 bits: mod 2^32 arithmetic.
  assign lcg_step = lcg_q * MULT + INC;

  // Merge the freshly stepped LCG word into the slot at idx.
  // The top word only has LAST_W bits of storage.
  always_comb begin
    wr_data = data_q;
    for (int k = 0; k < NWORDS - 1; k++) begin
      if (idx_q == IDX_W'(k))
        wr_data[32*k +: 32] = lcg_step;
    end
    if (idx_q == IDX_W'(NWORDS - 1))
      wr_data[IN_W-1 -: LAST_W] = lcg_step[LAST_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    lcg_d    = lcg_q;
    budget_d = budget_q;
    cyc_d    = cyc_q;
    rcnt_d   = rcnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RSTDUT;
            lcg_d    = seed;
            budget_d = cycles;
            cyc_d    = '0;
            rcnt_d   = '0;
            idx_d    = '0;
          end
        end
        RSTDUT: begin
          if (rcnt_q == RC_W'(RESET_CYCLES - 1))
            state_d = FILL;
          else
            rcnt_d = rcnt_q + 1'b1;
        end
        FILL: begin
          lcg_d  = lcg_step;
          data_d = wr_data;
          if (idx_q == IDX_W'(NWORDS - 1))
            state_d = PRESENT;
          else
            idx_d = idx_q + 1'b1;
        end
        PRESENT: begin
          if (vec_ready) begin
            cyc_d = cyc_q + 32'd1;
            // Old count decides, so an all-ones budget still ends.
            if (cyc_q == budget_q) begin
              state_d = DONE;
            end else begin
              idx_d   = '0;
              state_d = FILL;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lcg_q    <= '0;
      budget_q <= '0;
      cyc_q    <= '0;
      rcnt_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      lcg_q    <= lcg_d;
      budget_q <= budget_d;
      cyc_q    <= cyc_d;
      rcnt_q   <= rcnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign vec_valid = (state_q == PRESENT);
  assign dut_rst_n = (state_q == FILL) || (state_q == PRESENT) ||
                     (state_q == DONE);
  assign busy      = (state_q == RSTDUT) || (state_q == FILL) ||
                     (state_q == PRESENT);
  assign done      = (state_q == DONE);
  assign vec_data  = data_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer against a software LCG model.
// Drives start/abort/rst/vec_ready, checks stream, timing and status.
module tb_fuzz_stim_sequencer;

  localparam int IN_W = 263;
  localparam int NW   = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [31:0]     seed = '0;
  logic [31:0]     cycles = '0;
  logic            vec_valid;
  logic            vec_ready = 1'b0;
  logic [IN_W-1:0] vec_data;
  logic            dut_rst_n;
  logic [31:0]     cyc_count;
  logic            busy;
  logic            done;

  int checks = 0;
  int failures = 0;
  logic [31:0] m;

  fuzz_stim_sequencer #(.IN_W(IN_W), .RESET_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .seed(seed), .cycles(cycles), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_data(vec_data),
    .dut_rst_n(dut_rst_n), .cyc_count(cyc_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [287:0] obs,
                       input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic next_vec(output logic [IN_W-1:0] v);
    logic [287:0] full;
    full = '0;
    for (int k = 0; k < NW; k++) begin
      m = lcg(m);
      full[32*k +: 32] = m;
    end
    v = full[IN_W-1:0];
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] c);
    vec_ready = 1'b0;
    seed = s;
    cycles = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (vec_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_stream(input logic [31:0] s, input logic [31:0] c,
                            input int pct, output logic [IN_W-1:0] last);
    logic [IN_W-1:0] exp;
    logic [IN_W-1:0] held;
    int n, lat, acc, guard;
    bit hold;
    m = s;
    last = '0;
    held = '0;
    do_start(s, c);
    check("start_busy", 288'(busy), 288'(1));
    check("start_cyc0", 288'(cyc_count), 288'(0));
    n = 0;
    while (dut_rst_n === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check("rst_low_clocks", 288'(n), 288'(2));
    wait_valid(lat);
    check("fill_latency", 288'(lat), 288'(9));
    acc = 0;
    guard = 0;
    hold = 1'b0;
    while (done !== 1'b1 && guard < 20000) begin
      if (vec_valid === 1'b1) begin
        if (!hold) begin
          next_vec(exp);
          last = exp;
          check("vec_data", 288'(vec_data), 288'(exp));
        end else begin
          check("vec_stable", 288'(vec_data), 288'(held));
        end
        held = vec_data;
        vec_ready = ($urandom_range(0, 99) < pct);
        hold = !vec_ready;
        if (vec_ready) acc++;
      end else begin
        vec_ready = $urandom_range(0, 1) == 1;
      end
      tick();
      guard++;
    end
    vec_ready = 1'b0;
    check("end_done", 288'(done), 288'(1));
    check("end_busy", 288'(busy), 288'(0));
    check("end_valid", 288'(vec_valid), 288'(0));
    check("end_dut_rst_n", 288'(dut_rst_n), 288'(1));
    check("end_cyc_count", 288'(cyc_count), 288'(c + 32'd1));
    check("end_accepted", 288'(acc), 288'(c + 32'd1));
    check("end_data_held", 288'(vec_data), 288'(last));
  endtask

  initial begin
    logic [IN_W-1:0] v, ev;
    logic [31:0] s;
    int lat, g;

    // Reset state
    tick();
    check("rst_valid", 288'(vec_valid), 288'(0));
    check("rst_data", 288'(vec_data), 288'(0));
    check("rst_dut_rst_n", 288'(dut_rst_n), 288'(0));
    check("rst_cyc", 288'(cyc_count), 288'(0));
    check("rst_busy", 288'(busy), 288'(0));
    check("rst_done", 288'(done), 288'(0));
    rst = 1'b0;
    tick();

    // 1: seed 0, single vector
    run_stream(32'd0, 32'd0, 100, v);
    check("s1_word0", 288'(vec_data[31:0]), 288'(32'h00003039));
    check("s1_word1", 288'(vec_data[63:32]), 288'(32'hD3DC167E));
    check("s1_cyc", 288'(cyc_count), 288'(1));

    // 2: seed 1, top word truncation
    run_stream(32'd1, 32'd0, 100, v);
    check("s2_word0", 288'(vec_data[31:0]), 288'(32'h41C67EA6));
    s = 32'd1;
    for (int k = 0; k < NW; k++) s = lcg(s);
    check("s2_top7", 288'(vec_data[262:256]), 288'(s[6:0]));

    // 3: long run with 30% ready duty
    run_stream(32'd519709079, 32'd99, 30, v);
    check("s3_cyc", 288'(cyc_count), 288'(100));

    // 4: abort mid-fill of vector 5
    do_start(32'd77, 32'd99);
    vec_ready = 1'b1;
    g = 0;
    while (cyc_count !== 32'd4 && g < 500) begin
      tick();
      g++;
    end
    check("s4_reach4", 288'(cyc_count), 288'(4));
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec_ready = 1'b0;
    check("s4_valid", 288'(vec_valid), 288'(0));
    check("s4_dut_rst_n", 288'(dut_rst_n), 288'(0));
    check("s4_busy", 288'(busy), 288'(0));
    check("s4_done", 288'(done), 288'(0));
    check("s4_cyc", 288'(cyc_count), 288'(4));
    tick();
    check("s4_idle_busy", 288'(busy), 288'(0));
    run_stream(32'd12345, 32'd2, 100, v);

    // 5: start ignored while running
    m = 32'hCAFE0001;
    do_start(32'hCAFE0001, 32'd1);
    g = 0;
    while (dut_rst_n !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    tick();
    tick();
    seed = 32'h00BADBAD;
    cycles = 32'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    next_vec(ev);
    check("s5_vec0", 288'(vec_data), 288'(ev));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s5_still_valid", 288'(vec_valid), 288'(1));
    check("s5_stable", 288'(vec_data), 288'(ev));
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    wait_valid(lat);
    next_vec(ev);
    check("s5_vec1", 288'(vec_data), 288'(ev));
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("s5_done", 288'(done), 288'(1));
    check("s5_cyc", 288'(cyc_count), 288'(2));
    abort = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("s5_sa_busy", 288'(busy), 288'(0));
    check("s5_sa_rst_n", 288'(dut_rst_n), 288'(0));
    tick();
    check("s5_sa_idle", 288'(busy), 288'(0));

    // 6: async reset in PRESENT, then replay scenario 3
    do_start(32'd519709079, 32'd99);
    wait_valid(lat);
    check("s6_present", 288'(vec_valid), 288'(1));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("s6_valid", 288'(vec_valid), 288'(0));
    check("s6_data", 288'(vec_data), 288'(0));
    check("s6_dut_rst_n", 288'(dut_rst_n), 288'(0));
    check("s6_cyc", 288'(cyc_count), 288'(0));
    check("s6_busy", 288'(busy), 288'(0));
    check("s6_done", 288'(done), 288'(0));
    tick();
    rst = 1'b0;
    tick();
    run_stream(32'd519709079, 32'd99, 30, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
